// File: rtl/rgu_pixel_scheduler.sv
// rtl/rgu_pixel_scheduler.sv - walks every pixel of a frame through the ray generation unit
// Optional watchdog and oError port: define RGU_SCHED_TIMEOUT_EN.

module rgu_pixel_scheduler #(
  parameter int         PUSHES_PER_RAY = 3,
  parameter logic [7:0] REG_PIXEL_X    = 8'd1,
  parameter logic [7:0] REG_PIXEL_Y    = 8'd2
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [15:0] iResX,
  input  logic [15:0] iResY,
  input  logic        iRguFifoPush,
  input  logic        iFifoAlmostFull,
  output logic        oRguEnable,
  output logic        oRguReset,
  output logic        oRguSelected,
  output logic        oRguWrite,
  output logic [7:0]  oRguAddr,
  output logic [31:0] oRguData,
  output logic [15:0] oPixelX,
  output logic [15:0] oPixelY,
  output logic        oBusy,
`ifdef RGU_SCHED_TIMEOUT_EN
  output logic        oDone,
  output logic        oError
`else
  output logic        oDone
`endif
);

  localparam int PCW = $clog2(PUSHES_PER_RAY + 1);
  localparam logic [PCW-1:0] LAST_PUSH = PCW'(PUSHES_PER_RAY - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_X, LOAD_Y, RESTART, RUN, STALL, NEXT, DONE
  } stateT;

  stateT          state;
  stateT          nextState;
  logic [PCW-1:0] pushCount;
  logic [15:0]    resX;
  logic [15:0]    resY;
  logic           active;
  logic           finalPush;
  logic           lastPixel;
  logic           startOk;
  logic           timeout;

  // RUN and STALL are the only states in which pushes belong to the current pixel
  assign active    = (state == RUN) || (state == STALL);
  assign finalPush = active && iRguFifoPush && (pushCount == LAST_PUSH);
  assign lastPixel = (oPixelX == resX - 16'd1) && (oPixelY == resY - 16'd1);
  assign startOk   = (iResX != 16'd0) && (iResY != 16'd0);

`ifdef RGU_SCHED_TIMEOUT_EN
  logic [15:0] wdCount;

  // Fires on the cycle the count steps onto FFFF, so DONE lands 65535 cycles after RUN entry
  assign timeout = active && !iRguFifoPush && (wdCount == 16'hFFFE);

  // Watchdog: counts idle cycles of a pixel, restarts on every push
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wdCount <= 16'd0;
      oError  <= 1'b0;
    end else begin
      if (state == IDLE && iStart) oError <= 1'b0;
      if (timeout) oError <= 1'b1;
      if (state == RESTART || iRguFifoPush) wdCount <= 16'd0;
      else if (active && wdCount != 16'hFFFF) wdCount <= wdCount + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register; reset wins over everything
  always_ff @(posedge iClock) begin
    if (iReset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; a completing push outranks both stall and timeout
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = startOk ? LOAD_X : DONE;
      LOAD_X:  nextState = LOAD_Y;
      LOAD_Y:  nextState = RESTART;
      RESTART: nextState = RUN;
      RUN: begin
        if (finalPush)            nextState = NEXT;
        else if (timeout)         nextState = DONE;
        else if (iFifoAlmostFull) nextState = STALL;
      end
      STALL: begin
        if (finalPush)             nextState = NEXT;
        else if (timeout)          nextState = DONE;
        else if (!iFifoAlmostFull) nextState = RUN;
      end
      NEXT:    nextState = lastPixel ? DONE : LOAD_X;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state; enable drops combinationally on the completing push
  always_comb begin
    oRguEnable = 1'b0;
    oRguReset  = iReset;
    oRguWrite  = 1'b0;
    oRguAddr   = 8'd0;
    oRguData   = 32'd0;
    oDone      = 1'b0;
    case (state)
      LOAD_X: begin
        oRguWrite = 1'b1;
        oRguAddr  = REG_PIXEL_X;
        oRguData  = {16'd0, oPixelX};
      end
      LOAD_Y: begin
        oRguWrite = 1'b1;
        oRguAddr  = REG_PIXEL_Y;
        oRguData  = {16'd0, oPixelY};
      end
      RESTART: oRguReset  = 1'b1;
      RUN:     oRguEnable = !finalPush;
      DONE:    oDone      = 1'b1;
      default: ;
    endcase
  end

  assign oRguSelected = oRguWrite;
  assign oBusy        = (state != IDLE);

  // Frame bookkeeping: latched resolution, pixel scan position, push tally
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oPixelX   <= 16'd0;
      oPixelY   <= 16'd0;
      resX      <= 16'd0;
      resY      <= 16'd0;
      pushCount <= '0;
    end else begin
      if (state == IDLE && iStart) begin
        oPixelX   <= 16'd0;
        oPixelY   <= 16'd0;
        resX      <= iResX;
        resY      <= iResY;
        pushCount <= '0;
      end
      if (active && iRguFifoPush) begin
        pushCount <= (pushCount == LAST_PUSH) ? '0 : pushCount + PCW'(1);
      end
      if (state == NEXT) begin
        if (oPixelX == resX - 16'd1) begin
          oPixelX <= 16'd0;
          oPixelY <= oPixelY + 16'd1;
        end else begin
          oPixelX <= oPixelX + 16'd1;
        end
      end
    end
  end

endmodule
